mux_n_to_1_pipe: RTL and testbench

MUX_N_TO_1_PIPE -- requirements
Module: mux_n_to_1_pipe

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_n_to_1_pipe_if.sv | 33 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/mux_n_to_1_pipe.sv | 98 +++++++++
 tb/tb_mux_n_to_1_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and default sizing for the pipelined N-to-1 multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N     = 4;

endpackage

// File: rtl/mux_n_to_1_pipe_if.sv
// Channel-side and output-side signals of mux_n_to_1_pipe, bundled with master/slave views.
interface mux_n_to_1_pipe_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = $clog2(N)
) ();

    // Handshake: a word moves on a channel or on the output in any cycle where its
    // valid and ready are both high at the rising edge; ready never depends on a
    // future valid, and a producer holds valid/data until the transfer happens.
    mode_e                  mode;
    logic [SELW-1:0]        sel;
    logic [N*WIDTH-1:0]     in_data;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_sel;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any
);

    logic [SELW:0]   pos;
    logic [SELW-1:0] idx;

    // One extra bit on pos so ptr + i cannot overflow before the modulo-N fold.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (SELW+1)'(i);
            if (pos >= (SELW+1)'(N)) begin
                pos = pos - (SELW+1)'(N);
            end
            idx = pos[SELW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// N-to-1 multiplexer with one registered output stage, explicit-select or round-robin grant.
module mux_n_to_1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    mux_n_to_1_pipe_if.slave bus,
    output logic [SELW-1:0] rr_ptr
);

    logic [N-1:0]     rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic             accept;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [N-1:0]     grant_vec;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0]  ptr_next;

    logic [WIDTH-1:0] out_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;
    logic [SELW-1:0]  ptr_q;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr (
        .req       (bus.in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    assign accept = !valid_q || bus.out_ready;

    // Explicit select compares against every legal index, so sel >= N simply never matches.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_vec  = '0;
        grant_data = '0;
        if (bus.mode == MODE_RR) begin
            grant_any = rr_any;
            grant_idx = rr_idx;
            grant_vec = rr_grant;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    grant_any    = 1'b1;
                    grant_idx    = SELW'(i);
                    grant_vec[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;

    // Reset gates ready directly: the empty stage would otherwise look ready during reset.
    assign bus.in_ready = (reset_n && accept && grant_any) ? grant_vec : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (accept) begin
            valid_q <= grant_any;
            if (grant_any) begin
                out_q <= grant_data;
                sel_q <= grant_idx;
                if (bus.mode == MODE_RR) begin
                    ptr_q <= ptr_next;
                end
            end
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
    assign rr_ptr        = ptr_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Self-checking bench for mux_n_to_1_pipe (WIDTH=16, N=4) with a behavioural reference model.
module tb_mux_n_to_1_pipe;
    import mux_pkg::*;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int SELW = 2;
    localparam int BW   = 1 + SELW + W + SELW;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic [SELW-1:0] rr_ptr;

    mux_n_to_1_pipe_if #(.WIDTH(W), .N(N), .SELW(SELW)) bus ();

    mux_n_to_1_pipe #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .rr_ptr  (rr_ptr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0]    exp_out   = '0;
    logic [SELW-1:0] exp_sel   = '0;
    logic            exp_valid = 1'b0;
    int              exp_ptr   = 0;

    task automatic model_reset();
        exp_out   = '0;
        exp_sel   = '0;
        exp_valid = 1'b0;
        exp_ptr   = 0;
    endtask

    function automatic void model_grant(output bit any, output int g);
        any = 1'b0;
        g   = 0;
        if (bus.mode == MODE_SEL) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
                any = 1'b1;
                g   = int'(bus.sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (exp_ptr + k) % N;
                if (!any && bus.in_valid[c]) begin
                    any = 1'b1;
                    g   = c;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        bit any;
        int g;
        logic [N-1:0] r = '0;
        model_grant(any, g);
        if (any && (!exp_valid || bus.out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [BW-1:0] got_bundle();
        return {bus.out_valid, bus.out_sel, bus.out_data, rr_ptr};
    endfunction

    function automatic logic [BW-1:0] want_bundle();
        return {exp_valid, exp_sel, exp_out, SELW'(exp_ptr)};
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    function automatic logic [N*W-1:0] put(input logic [N*W-1:0] base, input int ch,
                                           input logic [W-1:0] v);
        base[ch*W +: W] = v;
        return base;
    endfunction

    task automatic drive(input mode_e m, input logic [SELW-1:0] s, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input logic r);
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
    endtask

    // Advance the model by the rules for one edge, then let the DUT take that edge.
    task automatic tick();
        bit any;
        int g;
        model_grant(any, g);
        if (!exp_valid || bus.out_ready) begin
            if (any) begin
                exp_out   = bus.in_data[g*W +: W];
                exp_sel   = SELW'(g);
                exp_valid = 1'b1;
                if (bus.mode == MODE_RR) exp_ptr = (g + 1) % N;
            end else begin
                exp_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(MODE_SEL, 2'd0, 4'b1111, rand_data(), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got_bundle() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", got_bundle());
        end
        n_cmp++;
        if (bus.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
        end
        reset_n = 1'b1;
        model_reset();
        drive(MODE_SEL, 2'd0, 4'b0001, put('0, 0, 16'h0F0F), 1'b1);
        n_cmp++;
        if (bus.in_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL first_accept_ready: got %b want 0001", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (got_bundle() !== want_bundle() || bus.out_data !== 16'h0F0F) begin
            n_err++;
            $display("FAIL first_accept_out: got %h want %h", got_bundle(), want_bundle());
        end
    endtask

    task automatic test_sel_basic();
        drive(MODE_SEL, 2'd2, 4'b0100, put(rand_data(), 2, 16'hBEEF), 1'b1);
        n_cmp++;
        if (bus.in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL sel2_ready: got %b want 0100", bus.in_ready);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd2, 16'hBEEF}) begin
            n_err++;
            $display("FAIL sel2_out: got %b/%0d/%h want 1/2/beef",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
        drive(MODE_SEL, 2'd1, 4'b1101, rand_data(), 1'b1);
        n_cmp++;
        if (bus.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL sel_invalid_ready: got %b want 0000", bus.in_ready);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b0, 2'd2, 16'hBEEF}) begin
            n_err++;
            $display("FAIL sel_invalid_out: got %b/%0d/%h want 0/2/beef",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
        for (int s = 0; s < N; s++) begin
            drive(MODE_SEL, SELW'(s), 4'($urandom_range(0, 15)), rand_data(), 1'b1);
            n_cmp++;
            if (bus.in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL sel_sweep_ready[%0d]: got %b want %b", s, bus.in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (got_bundle() !== want_bundle()) begin
                n_err++;
                $display("FAIL sel_sweep_out[%0d]: got %h want %h", s, got_bundle(), want_bundle());
            end
        end
    endtask

    task automatic test_rr_full();
        logic [N-1:0] want_r;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(MODE_RR, 2'd0, 4'b1111, rand_data(), 1'b1);
            want_r = '0;
            want_r[i % N] = 1'b1;
            n_cmp++;
            if (bus.in_ready !== want_r) begin
                n_err++;
                $display("FAIL rr_full_ready[%0d]: got %b want %b", i, bus.in_ready, want_r);
            end
            tick();
            n_cmp++;
            if ({bus.out_valid, bus.out_sel} !== {1'b1, SELW'(i % N)} || got_bundle() !== want_bundle()) begin
                n_err++;
                $display("FAIL rr_full_out[%0d]: got %h want %h", i, got_bundle(), want_bundle());
            end
        end
    endtask

    task automatic test_rr_sparse();
        int g_exp[3] = '{1, 3, 1};
        int p_exp[3] = '{2, 0, 2};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(MODE_RR, 2'd0, 4'b1010, rand_data(), 1'b1);
            n_cmp++;
            if (bus.in_ready !== N'(1 << g_exp[i])) begin
                n_err++;
                $display("FAIL rr_sparse_ready[%0d]: got %b want %b", i, bus.in_ready, N'(1 << g_exp[i]));
            end
            tick();
            n_cmp++;
            if ({bus.out_sel, rr_ptr} !== {SELW'(g_exp[i]), SELW'(p_exp[i])}) begin
                n_err++;
                $display("FAIL rr_sparse_grant[%0d]: got sel %0d ptr %0d want sel %0d ptr %0d",
                         i, bus.out_sel, rr_ptr, g_exp[i], p_exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        drive(MODE_SEL, 2'd0, 4'b0001, put(rand_data(), 0, 16'h1234), 1'b1);
        tick();
        n_cmp++;
        if (bus.out_data !== 16'h1234 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_load: got %b/%h want 1/1234", bus.out_valid, bus.out_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(mode_e'($urandom_range(0, 1)), SELW'(i + 1), 4'b1111, rand_data(), 1'b0);
            n_cmp++;
            if (bus.in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", i, bus.in_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_data !== 16'h1234 || got_bundle() !== want_bundle()) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, got_bundle(), want_bundle());
            end
        end
        drive(MODE_SEL, 2'd3, 4'b1111, put(rand_data(), 3, 16'h5678), 1'b1);
        n_cmp++;
        if (bus.in_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL stall_release_ready: got %b want 1000", bus.in_ready);
        end
        tick();
        n_cmp++;
        if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd3, 16'h5678}) begin
            n_err++;
            $display("FAIL stall_release_out: got %b/%0d/%h want 1/3/5678",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_reset_stall();
        drive(MODE_RR, 2'd0, 4'b0100, put(rand_data(), 2, 16'hABCD), 1'b1);
        tick();
        drive(MODE_RR, 2'd0, 4'b1111, rand_data(), 1'b0);
        tick();
        n_cmp++;
        if (got_bundle() !== want_bundle() || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_stall_pre: got %h want %h", got_bundle(), want_bundle());
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (got_bundle() !== '0) begin
            n_err++;
            $display("FAIL rst_stall_async: got %h want 0", got_bundle());
        end
        n_cmp++;
        if (bus.in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_stall_ready: got %b want 0000", bus.in_ready);
        end
        #2;
        reset_n = 1'b1;
        model_reset();
        drive(MODE_SEL, 2'd0, 4'b0000, rand_data(), 1'b0);
        tick();
        n_cmp++;
        if (got_bundle() !== want_bundle() || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stall_after: got %h want %h", got_bundle(), want_bundle());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(mode_e'($urandom_range(0, 1)), SELW'($urandom_range(0, N-1)),
                  4'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 3) != 0));
            n_cmp++;
            if (bus.in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (got_bundle() !== want_bundle()) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got %h want %h", i, got_bundle(), want_bundle());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_rr_full();
        test_rr_sparse();
        test_stall();
        test_reset_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
